// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-atomic round-robin arbiter that builds the header and forwards payload onto the MAC byte stream
module mac_tx_arbiter #(
    parameter int          IFG_CYCLES = 12,
    parameter logic [15:0] IP_PRTC    = 16'h0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic        cmd_valid_in,
    input  logic [3:0]  cmd_code_in,
    output logic        cmd_ready_o,
    input  logic        data_req_in,
    input  logic [15:0] data_len_in,
    output logic        data_grant_o,
    input  logic [7:0]  data_tdata_in,
    input  logic        data_tvalid_in,
    input  logic        data_tlast_in,
    output logic        data_tready_o,
    output logic [7:0]  tx_tdata_out,
    output logic        tx_tvalid_out,
    output logic        tx_tlast_out,
    input  logic        tx_tready_in,
    output logic        busy_o,
    output logic        len_err_o
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PAD, S_DRAIN, S_GAP} state_t;
    state_t       r_state, w_next;
    logic [47:0]  r_dst, r_src;
    logic [3:0]   r_code;
    logic [15:0]  r_len, r_rem;
    logic         r_is_data, r_last_grant, r_drain;
    logic [4:0]   r_byte_cnt;
    logic [31:0]  r_gap_cnt;
    logic [7:0]   r_tdata;
    logic         r_tvalid, r_tlast, r_cmd_ready, r_data_grant, r_len_err;
    logic         w_space, w_load, w_fire_last, w_grant, w_pick_data, w_acc;
    logic         w_hdr_last_ld, w_gap_done, w_data_tready;
    logic [15:0]  w_dhdr;
    logic [143:0] w_hdr;
    logic [7:0]   w_hdr_byte;

    assign w_space       = !r_tvalid || tx_tready_in;
    assign w_load        = w_space && !r_tlast;
    assign w_fire_last   = r_tvalid && r_tlast && tx_tready_in;
    assign w_grant       = (r_state == S_IDLE) && (cmd_valid_in || data_req_in);
    assign w_pick_data   = data_req_in && (!cmd_valid_in || !r_last_grant);
    assign w_data_tready = ((r_state == S_PAYLOAD) && w_load) || (r_state == S_DRAIN);
    assign w_acc         = data_tvalid_in && w_data_tready;
    assign w_hdr_last_ld = (r_state == S_HDR) && w_load && (r_byte_cnt == 5'd17);
    assign w_gap_done    = (r_gap_cnt + 32'd2) >= 32'(IFG_CYCLES);
    assign w_dhdr        = r_is_data ? 16'h4100 : {4'b1000, r_code, 8'h00};
    assign w_hdr         = {r_dst, r_src, IP_PRTC, w_dhdr, r_len};
    assign w_hdr_byte    = 8'(w_hdr >> (8'd136 - {r_byte_cnt, 3'b000}));

    // state register
    always_ff @(posedge clk) begin
        r_state <= !reset ? S_IDLE : w_next;
    end

    // next-state: frames run atomically, GAP ends the frame before re-arbitration
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_grant ? S_HDR : S_IDLE;
            S_HDR:     w_next = (w_hdr_last_ld && r_len != 16'd0) ? S_PAYLOAD : w_fire_last ? S_GAP : S_HDR;
            S_PAYLOAD: w_next = w_fire_last ? (r_drain ? S_DRAIN : S_GAP) :
                                (w_acc && data_tlast_in && r_rem > 16'd1) ? S_PAD : S_PAYLOAD;
            S_PAD:     w_next = w_fire_last ? S_GAP : S_PAD;
            S_DRAIN:   w_next = (w_acc && data_tlast_in) ? S_GAP : S_DRAIN;
            S_GAP:     w_next = w_gap_done ? S_IDLE : S_GAP;
            default:   w_next = S_IDLE;
        endcase
    end

    // datapath: grant latching, output byte register (loads only when empty or being consumed), counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dst        <= '0;
            r_src        <= '0;
            r_code       <= '0;
            r_len        <= '0;
            r_rem        <= '0;
            r_is_data    <= 1'b0;
            r_last_grant <= 1'b1;
            r_drain      <= 1'b0;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_data_grant <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_cmd_ready  <= w_grant && !w_pick_data;
            r_data_grant <= w_grant && w_pick_data;
            r_len_err    <= (r_state == S_PAYLOAD) && w_acc && (data_tlast_in ? r_rem > 16'd1 : r_rem == 16'd1);
            r_gap_cnt    <= (r_state == S_GAP) ? r_gap_cnt + 32'd1 : 32'd0;
            if (w_grant) begin
                r_dst      <= dst_mac;
                r_src      <= src_mac;
                r_is_data  <= w_pick_data;
                r_code     <= w_pick_data ? 4'h0 : cmd_code_in;
                r_len      <= w_pick_data ? data_len_in : 16'h0000;
                r_byte_cnt <= '0;
                r_drain    <= 1'b0;
            end else if ((r_state == S_PAYLOAD) && w_acc && r_rem == 16'd1 && !data_tlast_in) begin
                r_drain <= 1'b1;
            end
            if (w_fire_last)
                r_last_grant <= r_is_data;
            if ((r_state == S_HDR) && w_load) begin
                r_tdata    <= w_hdr_byte;
                r_tvalid   <= 1'b1;
                r_tlast    <= (r_byte_cnt == 5'd17) && (r_len == 16'd0);
                r_byte_cnt <= r_byte_cnt + 5'd1;
                if (r_byte_cnt == 5'd17)
                    r_rem <= r_len;
            end else if ((r_state == S_PAYLOAD) && w_load) begin
                r_tdata  <= data_tdata_in;
                r_tvalid <= w_acc;
                r_tlast  <= w_acc && (r_rem == 16'd1);
                if (w_acc)
                    r_rem <= r_rem - 16'd1;
            end else if ((r_state == S_PAD) && w_load) begin
                r_tdata  <= 8'h00;
                r_tvalid <= 1'b1;
                r_tlast  <= (r_rem == 16'd1);
                r_rem    <= r_rem - 16'd1;
            end else if (w_space) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign data_grant_o  = r_data_grant;
    assign data_tready_o = w_data_tready;
    assign tx_tdata_out  = r_tdata;
    assign tx_tvalid_out = r_tvalid;
    assign tx_tlast_out  = r_tlast;
    assign busy_o        = (r_state != S_IDLE);
    assign len_err_o     = r_len_err;
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: scoreboard bench with a frame-level reference model and randomized traffic
module tb_mac_tx_arbiter;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] dst_mac = '0, src_mac = '0;
    logic        cmd_valid_in = 1'b0;
    logic [3:0]  cmd_code_in = '0;
    logic        cmd_ready_o;
    logic        data_req_in = 1'b0;
    logic [15:0] data_len_in = '0;
    logic        data_grant_o;
    logic [7:0]  data_tdata_in = '0;
    logic        data_tvalid_in = 1'b0;
    logic        data_tlast_in = 1'b0;
    logic        data_tready_o;
    logic [7:0]  tx_tdata_out;
    logic        tx_tvalid_out, tx_tlast_out;
    logic        tx_tready_in = 1'b1;
    logic        busy_o, len_err_o;

    mac_tx_arbiter #(.IFG_CYCLES(IFG), .IP_PRTC(16'h0800)) dut (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac),
        .cmd_valid_in(cmd_valid_in), .cmd_code_in(cmd_code_in), .cmd_ready_o(cmd_ready_o),
        .data_req_in(data_req_in), .data_len_in(data_len_in), .data_grant_o(data_grant_o),
        .data_tdata_in(data_tdata_in), .data_tvalid_in(data_tvalid_in), .data_tlast_in(data_tlast_in),
        .data_tready_o(data_tready_o), .tx_tdata_out(tx_tdata_out), .tx_tvalid_out(tx_tvalid_out),
        .tx_tlast_out(tx_tlast_out), .tx_tready_in(tx_tready_in), .busy_o(busy_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;
    int          n_err = 0, n_cmd = 0, n_dat = 0;
    int          exp_err = 0, exp_cmd = 0, exp_dat = 0;
    int          end_cyc = 0;
    int          rdy_mode = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  src_q[$];
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: a frame is 18 header bytes, then exactly len payload bytes
    // (source bytes while they last, zero padding after), tlast on the final byte
    task automatic push_frame(input bit is_data, input logic [3:0] code, input int len, input int n);
        logic [7:0]  h[18];
        logic [15:0] l;
        logic [7:0]  b;
        l = is_data ? 16'(len) : 16'h0000;
        for (int i = 0; i < 6; i++) begin
            h[i]     = dst_mac[47-8*i -: 8];
            h[6 + i] = src_mac[47-8*i -: 8];
        end
        h[12] = 8'h08;
        h[13] = 8'h00;
        h[14] = is_data ? 8'h41 : {4'h8, code};
        h[15] = 8'h00;
        h[16] = l[15:8];
        h[17] = l[7:0];
        for (int i = 0; i < 18; i++) exp_q.push_back({(l == 16'h0000) && (i == 17), h[i]});
        for (int i = 0; i < int'(l); i++) begin
            b = 8'h00;
            if (i < n) b = src_q[i];
            exp_q.push_back({i == int'(l) - 1, b});
        end
    endtask

    task automatic wait_grant(input bit is_data, output bit ok);
        int t = 0;
        while (!(is_data ? data_grant_o : cmd_ready_o) && t < 300) begin
            tick();
            t++;
        end
        ok = (t < 300);
        chk(is_data ? "data_grant_seen" : "cmd_ready_seen", 64'(ok), 64'd1);
        if (is_data) data_req_in = 1'b0;
        else cmd_valid_in = 1'b0;
    endtask

    task automatic send_src(input int n, input int total, input bit stall);
        int t;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (stall && $urandom % 3 == 0) begin
                data_tvalid_in = 1'b0;
                repeat (1 + $urandom % 3) tick();
            end
            data_tvalid_in = 1'b1;
            data_tdata_in  = src_q[i];
            data_tlast_in  = (i == total - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 500) begin
                @(negedge clk);
                acc = data_tready_o;
                tick();
                t++;
            end
            if (!acc) begin
                chk("src_accept", 64'(acc), 64'd1);
                break;
            end
        end
        data_tvalid_in = 1'b0;
        data_tlast_in  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_o || exp_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        chk("frame_done", {63'(exp_q.size()), busy_o}, 64'd0);
    endtask

    task automatic run_cmd(input logic [3:0] code);
        bit ok;
        cmd_code_in = code;
        push_frame(1'b0, code, 0, 0);
        cmd_valid_in = 1'b1;
        exp_cmd++;
        wait_grant(1'b0, ok);
        wait_idle();
    endtask

    task automatic run_data(input int len, input int n, input bit stall);
        bit ok;
        data_len_in = 16'(len);
        push_frame(1'b1, 4'h0, len, n);
        data_req_in = 1'b1;
        exp_dat++;
        if (n != len) exp_err++;
        wait_grant(1'b1, ok);
        if (ok) send_src(n, n, stall);
        wait_idle();
    endtask

    // MAC-side ready: always, toggling, or random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_tready_in = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~tx_tready_in : 1'($urandom % 2);
        end
    end

    // monitor: pops the scoreboard on every output handshake, checks stability under backpressure
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_under_stall", {tx_tvalid_out, tx_tlast_out, tx_tdata_out}, {1'b1, prev_beat});
            if (tx_tvalid_out && tx_tready_in) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {tx_tlast_out, tx_tdata_out}, 64'h1000);
                else chk("beat", {tx_tlast_out, tx_tdata_out}, exp_q.pop_front());
                if (tx_tlast_out) end_cyc = cyc;
            end
            prev_stall = tx_tvalid_out && !tx_tready_in;
            prev_beat  = {tx_tlast_out, tx_tdata_out};
            if (len_err_o) n_err++;
            if (cmd_ready_o) n_cmd++;
            if (data_grant_o) n_dat++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int len, n;
        repeat (3) tick();
        chk("reset_outputs", {tx_tvalid_out, tx_tlast_out, tx_tdata_out, busy_o, cmd_ready_o,
                              data_grant_o, len_err_o, data_tready_o}, 64'd0);
        reset = 1'b1;
        tick();

        // simultaneous requests after reset: cmd wins, data follows after the gap
        dst_mac = 48'h0A0B0C0D0E0F;
        src_mac = 48'h112233445566;
        src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cmd_code_in = 4'h5;
        data_len_in = 16'd4;
        push_frame(1'b0, 4'h5, 0, 0);
        push_frame(1'b1, 4'h0, 4, 4);
        exp_cmd++;
        exp_dat++;
        cmd_valid_in = 1'b1;
        data_req_in  = 1'b1;
        wait_grant(1'b0, ok);
        wait_grant(1'b1, ok);
        if (ok) chk("gap_cmd_to_data", 64'(cyc - end_cyc - 1), 64'(IFG));
        send_src(4, 4, 1'b0);
        wait_idle();
        chk("no_len_err_data4", 64'(n_err), 64'(exp_err));

        // cmd only, so the last grant is cmd; then simultaneous requests grant data first
        run_cmd(4'h5);
        dst_mac = 48'hFFEEDDCCBBAA;
        push_frame(1'b1, 4'h0, 4, 4);
        push_frame(1'b0, 4'h1, 0, 0);
        exp_cmd++;
        exp_dat++;
        cmd_code_in  = 4'h1;
        cmd_valid_in = 1'b1;
        data_req_in  = 1'b1;
        wait_grant(1'b1, ok);
        if (ok) send_src(4, 4, 1'b0);
        wait_grant(1'b0, ok);
        if (ok) chk("gap_data_to_cmd", 64'(cyc - end_cyc - 1), 64'(IFG));
        wait_idle();

        // backpressure: toggling ready must give the same byte stream
        rdy_mode = 1;
        run_data(4, 4, 1'b0);
        rdy_mode = 0;
        chk("no_len_err_toggle", 64'(n_err), 64'(exp_err));

        // early source tlast: padded with zeros, one error pulse
        src_q = '{8'h11, 8'h22};
        run_data(4, 2, 1'b0);
        chk("len_err_early", 64'(n_err), 64'(exp_err));

        // late source tlast: extra bytes drained, one error pulse
        src_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run_data(2, 5, 1'b0);
        chk("len_err_late", 64'(n_err), 64'(exp_err));

        // randomized traffic
        for (int k = 0; k < 24; k++) begin
            rdy_mode = $urandom % 3;
            dst_mac = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
            src_mac = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
            if ($urandom % 2 == 0) begin
                case ($urandom % 3)
                    0: run_cmd(4'h1);
                    1: run_cmd(4'h5);
                    default: run_cmd(4'hA);
                endcase
            end else begin
                len = 1 + $urandom % 8;
                n = ($urandom % 3 == 0) ? 1 + $urandom % 10 : len;
                src_q.delete();
                for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
                run_data(len, n, 1'b1);
            end
        end
        rdy_mode = 0;
        repeat (2) tick();
        chk("len_err_random", 64'(n_err), 64'(exp_err));

        // reset in the middle of the payload abandons the frame
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h50 + i));
        data_len_in = 16'd8;
        push_frame(1'b1, 4'h0, 8, 8);
        data_req_in = 1'b1;
        exp_dat++;
        wait_grant(1'b1, ok);
        if (ok) send_src(2, 8, 1'b0);
        reset = 1'b0;
        data_tvalid_in = 1'b0;
        tick();
        chk("reset_midframe", {tx_tvalid_out, busy_o}, 64'd0);
        exp_q.delete();
        reset = 1'b1;
        tick();
        dst_mac = 48'h010203040506;
        run_cmd(4'hA);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("len_err_total", 64'(n_err), 64'(exp_err));
        chk("cmd_ready_pulses", 64'(n_cmd), 64'(exp_cmd));
        chk("data_grant_pulses", 64'(n_dat), 64'(exp_dat));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
